pc_sequencer: RTL and testbench

- Controller for the program-counter register: drives the register's write enable and data input and sequences instruction fetch over a req/ack handshake.
- Presents fetched instructions to decode over a valid/ready handshake.
- Applies branch and exception redirects with a fixed priority.
- Sits between the PC Register instance, instruction memory and decode.

---
 rtl/scp_pkg.sv | 33 +++
 rtl/pc_redirect_sel.sv | 34 +++
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scp_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, redirect kinds
// and the default reset/vector addresses.
package scp_pkg;

  localparam logic [31:0] DEF_RESET_VALUE = 32'h0000_0040;
  localparam logic [31:0] DEF_VECTOR_ADDR = 32'h0000_0020;
  localparam int          DEF_INC         = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } seqState_t;

  // Redirect sources, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    REDIR_SEQ = 2'd0,
    REDIR_BR  = 2'd1,
    REDIR_EXC = 2'd2
  } redirKind_t;

  function automatic redirKind_t redirPrio(input logic excReq, input logic brTaken);
    redirKind_t kind;
    kind = REDIR_SEQ;
    if (excReq) begin
      kind = REDIR_EXC;
    end else if (brTaken) begin
      kind = REDIR_BR;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority mux for the next PC: exception vector over branch target over the
// sequential increment.
module pc_redirect_sel
  import scp_pkg::*;
#(
  parameter int                   BIT_WIDTH   = 32,
  parameter logic [BIT_WIDTH-1:0] VECTOR_ADDR = BIT_WIDTH'(DEF_VECTOR_ADDR),
  parameter int                   INC         = DEF_INC
) (
  input  logic [BIT_WIDTH-1:0] pcCur,
  input  logic                 excReq,
  input  logic                 brTaken,
  input  logic [BIT_WIDTH-1:0] brTarget,
  output logic                 redirValid,
  output redirKind_t           redirKind,
  output logic [BIT_WIDTH-1:0] redirTarget,
  output logic [BIT_WIDTH-1:0] seqPc
);

  // Modulo 2^BIT_WIDTH: the carry out of the top bit is dropped on purpose.
  assign seqPc = pcCur + BIT_WIDTH'(INC);

  always_comb begin
    redirKind   = redirPrio(excReq, brTaken);
    redirValid  = (redirKind != REDIR_SEQ);
    redirTarget = seqPc;
    case (redirKind)
      REDIR_EXC: redirTarget = VECTOR_ADDR;
      REDIR_BR:  redirTarget = brTarget;
      default:   redirTarget = seqPc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: drives the external PC register, fetches over
// imemReq/imemAck and offers each instruction to decode until accepted.
module pc_sequencer
  import scp_pkg::*;
#(
  parameter int                   BIT_WIDTH   = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = BIT_WIDTH'(DEF_RESET_VALUE),
  parameter logic [BIT_WIDTH-1:0] VECTOR_ADDR = BIT_WIDTH'(DEF_VECTOR_ADDR),
  parameter int                   INC         = DEF_INC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] pcCur,
  output logic                 pcWrtEn,
  output logic [BIT_WIDTH-1:0] pcNext,
  output logic                 imemReq,
  output logic [BIT_WIDTH-1:0] imemAddr,
  input  logic                 imemAck,
  input  logic [31:0]          imemData,
  output logic                 instrValid,
  output logic [31:0]          instr,
  output logic [BIT_WIDTH-1:0] instrPc,
  input  logic                 instrReady,
  input  logic                 stall,
  input  logic                 brTaken,
  input  logic [BIT_WIDTH-1:0] brTarget,
  input  logic                 excReq,
  output logic                 excAck
);

  seqState_t            stateReg;
  logic                 instrValidReg;
  logic [31:0]          instrReg;
  logic [BIT_WIDTH-1:0] instrPcReg;
  logic                 excAckReg;
  logic                 pendReg;
  logic [BIT_WIDTH-1:0] pendAddrReg;
  redirKind_t           pendKindReg;

  logic                 redirValid;
  redirKind_t           redirKind;
  logic [BIT_WIDTH-1:0] redirTarget;
  logic [BIT_WIDTH-1:0] seqPc;
  logic                 accept;
  logic                 excWriteNext;

  pc_redirect_sel #(
    .BIT_WIDTH  (BIT_WIDTH),
    .VECTOR_ADDR(VECTOR_ADDR),
    .INC        (INC)
  ) redirSel (
    .pcCur      (pcCur),
    .excReq     (excReq),
    .brTaken    (brTaken),
    .brTarget   (brTarget),
    .redirValid (redirValid),
    .redirKind  (redirKind),
    .redirTarget(redirTarget),
    .seqPc      (seqPc)
  );

  assign imemAddr   = pcCur;
  assign accept     = instrReady & ~stall;
  assign instrValid = instrValidReg;
  assign instr      = instrReg;
  assign instrPc    = instrPcReg;
  assign excAck     = excAckReg;

  // PC write port and fetch request; reset forces the PC register to RESET_VALUE.
  always_comb begin
    pcWrtEn      = 1'b0;
    pcNext       = seqPc;
    imemReq      = 1'b0;
    excWriteNext = 1'b0;
    if (!reset) begin
      pcWrtEn = 1'b1;
      pcNext  = RESET_VALUE;
    end else begin
      case (stateReg)
        FETCH: begin
          imemReq = 1'b1;
          if (imemAck) begin
            pcWrtEn = 1'b1;
            if (redirValid) begin
              pcNext       = redirTarget;
              excWriteNext = (redirKind == REDIR_EXC);
            end else if (pendReg) begin
              pcNext       = pendAddrReg;
              excWriteNext = (pendKindReg == REDIR_EXC);
            end else begin
              pcNext = seqPc;
            end
          end
        end
        HOLD: begin
          if (redirValid) begin
            pcWrtEn      = 1'b1;
            pcNext       = redirTarget;
            excWriteNext = (redirKind == REDIR_EXC);
          end
        end
        default: begin
          pcWrtEn = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg      <= BOOT;
      instrValidReg <= 1'b0;
      instrReg      <= '0;
      instrPcReg    <= '0;
      excAckReg     <= 1'b0;
      pendReg       <= 1'b0;
      pendAddrReg   <= '0;
      pendKindReg   <= REDIR_SEQ;
    end else begin
      excAckReg <= excWriteNext;
      case (stateReg)
        BOOT: begin
          stateReg <= FETCH;
        end
        FETCH: begin
          if (imemAck) begin
            pendReg <= 1'b0;
            if (!redirValid && !pendReg) begin
              instrReg      <= imemData;
              instrPcReg    <= pcCur;
              instrValidReg <= 1'b1;
              stateReg      <= HOLD;
            end
          end else if (redirValid) begin
            // The fetch in flight cannot be cancelled; remember where to go once it lands.
            pendReg     <= 1'b1;
            pendAddrReg <= redirTarget;
            pendKindReg <= redirKind;
          end
        end
        HOLD: begin
          if (redirValid || accept) begin
            instrValidReg <= 1'b0;
            stateReg      <= FETCH;
          end
        end
        default: begin
          stateReg <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a cycle-level
// reference model that also owns the PC register the sequencer controls.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;
  localparam logic [31:0] VA = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcCur;
  logic        pcWrtEn;
  logic [31:0] pcNext;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = '0;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady = 1'b0;
  logic        stall = 1'b0;
  logic        brTaken = 1'b0;
  logic [31:0] brTarget = '0;
  logic        excReq = 1'b0;
  logic        excAck;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .pcCur     (pcCur),
    .pcWrtEn   (pcWrtEn),
    .pcNext    (pcNext),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemData  (imemData),
    .instrValid(instrValid),
    .instr     (instr),
    .instrPc   (instrPc),
    .instrReady(instrReady),
    .stall     (stall),
    .brTaken   (brTaken),
    .brTarget  (brTarget),
    .excReq    (excReq),
    .excAck    (excAck)
  );

  // The PC register the sequencer drives.
  logic [31:0] pcReg;
  always_ff @(posedge clk) begin
    if (pcWrtEn) pcReg <= pcNext;
  end
  assign pcCur = pcReg;

  typedef struct packed {
    logic [31:0] addr;
    logic        isExc;
  } pend_t;

  // Reference model state.
  logic [31:0] mPc;
  bit          mPcKnown = 1'b0;
  bit          mBooted = 1'b0;
  bit          mHolding = 1'b0;
  logic [31:0] mInstr = '0;
  logic [31:0] mInstrPc = '0;
  bit          mExcAck = 1'b0;
  pend_t       pendQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare against the model mid-cycle, advance the model.
  task automatic cyc(input logic rst, input logic ack, input logic [31:0] data,
                     input logic rdy, input logic stl, input logic br,
                     input logic [31:0] brt, input logic exc);
    logic        redir;
    logic [31:0] tgt;
    logic        expWr;
    logic [31:0] expNext;
    logic        expReq;
    bit          nBooted, nHolding, nExc, clrPend, setPend;
    logic [31:0] nInstr, nInstrPc;
    pend_t       newPend;

    reset = rst; imemAck = ack; imemData = data; instrReady = rdy; stall = stl;
    brTaken = br; brTarget = brt; excReq = exc;

    redir    = exc | br;
    tgt      = exc ? VA : brt;
    expWr    = 1'b0;
    expNext  = mPc + 32'd4;
    expReq   = 1'b0;
    nBooted  = mBooted;
    nHolding = mHolding;
    nExc     = 1'b0;
    nInstr   = mInstr;
    nInstrPc = mInstrPc;
    clrPend  = 1'b0;
    setPend  = 1'b0;
    newPend  = '{addr: tgt, isExc: exc};

    if (!rst) begin
      expWr = 1'b1; expNext = RV;
      nBooted = 1'b0; nHolding = 1'b0; nInstr = '0; nInstrPc = '0; clrPend = 1'b1;
    end else if (!mBooted) begin
      nBooted = 1'b1;
    end else if (!mHolding) begin
      expReq = 1'b1;
      if (ack) begin
        expWr = 1'b1;
        clrPend = 1'b1;
        if (redir) begin
          expNext = tgt; nExc = exc;
        end else if (pendQ.size() > 0) begin
          expNext = pendQ[0].addr; nExc = pendQ[0].isExc;
        end else begin
          nHolding = 1'b1; nInstr = data; nInstrPc = mPc;
        end
      end else if (redir) begin
        setPend = 1'b1;
      end
    end else begin
      if (redir) begin
        expWr = 1'b1; expNext = tgt; nExc = exc; nHolding = 1'b0;
      end else if (rdy && !stl) begin
        nHolding = 1'b0;
      end
    end

    @(negedge clk);
    checkVal("pcWrtEn", {31'd0, pcWrtEn}, {31'd0, expWr});
    if (mPcKnown || !rst) checkVal("pcNext", pcNext, expNext);
    checkVal("imemReq", {31'd0, imemReq}, {31'd0, expReq});
    if (mPcKnown) begin
      checkVal("pcCur", pcCur, mPc);
      checkVal("imemAddr", imemAddr, mPc);
    end
    checkVal("instrValid", {31'd0, instrValid}, {31'd0, mHolding});
    checkVal("instr", instr, mInstr);
    checkVal("instrPc", instrPc, mInstrPc);
    checkVal("excAck", {31'd0, excAck}, {31'd0, mExcAck});

    @(posedge clk);
    #1;
    if (expWr) begin
      mPc = expNext;
      mPcKnown = 1'b1;
    end
    mBooted = nBooted; mHolding = nHolding; mInstr = nInstr; mInstrPc = nInstrPc;
    mExcAck = nExc;
    if (clrPend) pendQ.delete();
    if (setPend) begin
      pendQ.delete();
      pendQ.push_back(newPend);
    end
  endtask

  task automatic idle(input logic rdy, input logic stl);
    cyc(1'b1, 1'b0, 32'h0, rdy, stl, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        rst, ack, rdy, stl, br, exc;
    logic [31:0] data, brt;

    // Reset held for three cycles, then boot.
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 1'b0);
    checkVal("tp_first_req", {31'd0, imemReq}, 32'd1);
    checkVal("tp_first_addr", imemAddr, 32'h40);

    // Sequential fetch, ack after two wait cycles.
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkVal("tp_instr", instr, 32'hDEADBEEF);
    checkVal("tp_instrPc", instrPc, 32'h40);
    checkVal("tp_pc_adv", pcCur, 32'h44);

    // Stalled hold, then accept.
    repeat (4) idle(1'b1, 1'b1);
    checkVal("tp_stall_valid", {31'd0, instrValid}, 32'd1);
    checkVal("tp_stall_pc", pcCur, 32'h44);
    idle(1'b1, 1'b0);
    checkVal("tp_accept_valid", {31'd0, instrValid}, 32'd0);
    checkVal("tp_accept_addr", imemAddr, 32'h44);

    // Branch one cycle before ack discards the fetched word.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    cyc(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkVal("tp_br_discard", {31'd0, instrValid}, 32'd0);
    checkVal("tp_br_addr", imemAddr, 32'h100);

    // Exception and branch together in HOLD.
    cyc(1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    checkVal("tp_exc_squash", {31'd0, instrValid}, 32'd0);
    checkVal("tp_exc_pc", pcCur, VA);
    checkVal("tp_exc_ack", {31'd0, excAck}, 32'd1);
    idle(1'b0, 1'b0);
    checkVal("tp_exc_ack_end", {31'd0, excAck}, 32'd0);
    checkVal("tp_exc_addr", imemAddr, VA);

    // Wrap-around from the top of the address space.
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkVal("tp_wrap_addr", imemAddr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkVal("tp_wrap_pc", pcCur, 32'h0);
    checkVal("tp_wrap_instrPc", instrPc, 32'hFFFF_FFFC);

    // Reset in the middle of a fetch.
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkVal("tp_rst_req", {31'd0, imemReq}, 32'd0);
    checkVal("tp_rst_next", pcNext, RV);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) != 0);
      ack  = rst && mBooted && !mHolding && ($urandom_range(0, 2) == 0);
      data = $urandom();
      rdy  = ($urandom_range(0, 1) == 1);
      stl  = ($urandom_range(0, 3) == 0);
      br   = ($urandom_range(0, 7) == 0);
      brt  = $urandom() & 32'hFFFF_FFFC;
      exc  = ($urandom_range(0, 15) == 0);
      cyc(rst, ack, data, rdy, stl, br, brt, exc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
